// File: rtl/shrimp_pkg.sv
// Shared definitions for the shrimp register write-back path.
package shrimp_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;

  // Writes to this register are discarded; it reads as a constant elsewhere.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 4'hF;

  // One buffered load result; live clears when a newer ALU write supersedes it.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     val;
    logic                  live;
  } wb_entry_t;

  // Which source feeds the register-file write port on the next cycle.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_ALU    = 2'd1,
    SRC_BYPASS = 2'd2,
    SRC_FIFO   = 2'd3
  } wr_src_e;

endpackage

// File: rtl/shrimp_wb_fifo.sv
// Circular buffer of pending load results with per-address invalidation.
// A killed entry keeps its slot until it reaches the head and is popped.
import shrimp_pkg::*;

module shrimp_wb_fifo #(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_addr,
  output wb_entry_t             head,
  output logic [CW-1:0]         count
);

  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Next storage contents: clear live on address matches, then write the new entry.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en && (mem_q[i].addr == kill_addr)) begin
        mem_d[i].live = 1'b0;
      end
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
    end
  end

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap freely.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/shrimp_reg_writer.sv
// Register-file write arbiter: ALU results win every cycle, load results are
// bypassed when possible or buffered in order, and stale buffered loads are
// killed by newer ALU writes to the same register.
import shrimp_pkg::*;

module shrimp_reg_writer #(
  parameter int MEM_FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0]     alu_val,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_val,
  output logic [REG_ADDR_W-1:0] reg_w_addr,
  output logic [DATA_W-1:0]     reg_w_val,
  output logic                  reg_w_enable,
  output logic                  idle
);

  localparam int CW = $clog2(MEM_FIFO_DEPTH) + 1;

  logic [CW-1:0]         fifo_count;
  wb_entry_t             fifo_head;
  wb_entry_t             push_entry;
  logic                  fifo_empty;
  logic                  alu_sel;
  logic                  mem_accept;
  logic                  load_live;
  logic                  push;
  logic                  pop;
  wr_src_e               src;

  logic                  reg_w_enable_q, reg_w_enable_d;
  logic [REG_ADDR_W-1:0] reg_w_addr_q, reg_w_addr_d;
  logic [DATA_W-1:0]     reg_w_val_q, reg_w_val_d;

  assign fifo_empty = (fifo_count == '0);
  assign mem_ready  = (fifo_count < CW'(MEM_FIFO_DEPTH));
  assign alu_sel    = alu_valid && (alu_addr != ZERO_REG);
  assign mem_accept = mem_valid && mem_ready;
  assign load_live  = mem_accept && (mem_addr != ZERO_REG) &&
                      !(alu_sel && (mem_addr == alu_addr));
  assign push_entry = '{addr: mem_addr, val: mem_val, live: 1'b1};

  // Pick this cycle's write source and decide whether the FIFO pushes or pops.
  always_comb begin
    src  = SRC_NONE;
    pop  = 1'b0;
    push = 1'b0;
    if (alu_sel) begin
      src  = SRC_ALU;
      push = load_live;
    end else if (!fifo_empty) begin
      pop  = 1'b1;
      src  = fifo_head.live ? SRC_FIFO : SRC_NONE;
      push = load_live;
    end else if (load_live) begin
      src  = SRC_BYPASS;
    end
  end

  // Next value of the registered write port; address and data hold when idle.
  always_comb begin
    reg_w_enable_d = (src != SRC_NONE);
    reg_w_addr_d   = reg_w_addr_q;
    reg_w_val_d    = reg_w_val_q;
    case (src)
      SRC_ALU: begin
        reg_w_addr_d = alu_addr;
        reg_w_val_d  = alu_val;
      end
      SRC_BYPASS: begin
        reg_w_addr_d = mem_addr;
        reg_w_val_d  = mem_val;
      end
      SRC_FIFO: begin
        reg_w_addr_d = fifo_head.addr;
        reg_w_val_d  = fifo_head.val;
      end
      default: begin
        reg_w_addr_d = reg_w_addr_q;
        reg_w_val_d  = reg_w_val_q;
      end
    endcase
  end

  // Output registers; reset also cancels any write that was about to issue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_w_enable_q <= 1'b0;
      reg_w_addr_q   <= '0;
      reg_w_val_q    <= '0;
    end else begin
      reg_w_enable_q <= reg_w_enable_d;
      reg_w_addr_q   <= reg_w_addr_d;
      reg_w_val_q    <= reg_w_val_d;
    end
  end

  shrimp_wb_fifo #(
    .DEPTH (MEM_FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (alu_sel),
    .kill_addr  (alu_addr),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  assign reg_w_enable = reg_w_enable_q;
  assign reg_w_addr   = reg_w_addr_q;
  assign reg_w_val    = reg_w_val_q;
  assign idle         = fifo_empty && !reg_w_enable_q;

endmodule

// File: tb/tb_shrimp_reg_writer.sv
// Self-checking bench for shrimp_reg_writer: directed scenarios followed by
// random traffic, all compared against a queue-based model of the write rules.
module tb_shrimp_reg_writer;

  localparam int DEPTH = 2;

  logic        clock;
  logic        reset;
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [15:0] alu_val;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_addr;
  logic [15:0] mem_val;
  logic [3:0]  reg_w_addr;
  logic [15:0] reg_w_val;
  logic        reg_w_enable;
  logic        idle;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] v;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  logic        exp_en;
  logic [3:0]  exp_addr;
  logic [15:0] exp_val;

  shrimp_reg_writer #(.MEM_FIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_addr     (alu_addr),
    .alu_val      (alu_val),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_val      (mem_val),
    .reg_w_addr   (reg_w_addr),
    .reg_w_val    (reg_w_val),
    .reg_w_enable (reg_w_enable),
    .idle         (idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("reg_w_enable", 32'(reg_w_enable), 32'(exp_en));
    checkOutput("reg_w_addr", 32'(reg_w_addr), 32'(exp_addr));
    checkOutput("reg_w_val", 32'(reg_w_val), 32'(exp_val));
    checkOutput("mem_ready", 32'(mem_ready), 32'(mq.size() < DEPTH));
    checkOutput("idle", 32'(idle), 32'((mq.size() == 0) && !exp_en));
  endtask

  // Drive one cycle of inputs, check the current outputs, then advance the model.
  task automatic applyStimulus(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                               input logic mv, input logic [3:0] ma, input logic [15:0] md);
    bit   alu_w;
    bit   load_ok;
    bit   was_empty;
    ent_t e;
    @(negedge clock);
    alu_valid = av; alu_addr = aa; alu_val = ad;
    mem_valid = mv; mem_addr = ma; mem_val = md;
    #1;
    checkAll();
    alu_w     = av && (aa != 4'hF);
    load_ok   = mv && (mq.size() < DEPTH) && (ma != 4'hF) && !(alu_w && ma == aa);
    was_empty = (mq.size() == 0);
    if (alu_w) begin
      foreach (mq[i]) if (mq[i].a == aa) mq[i].live = 1'b0;
    end
    exp_en = 1'b0;
    if (alu_w) begin
      exp_en = 1'b1; exp_addr = aa; exp_val = ad;
    end else if (!was_empty) begin
      e = mq.pop_front();
      if (e.live) begin
        exp_en = 1'b1; exp_addr = e.a; exp_val = e.v;
      end
    end else if (load_ok) begin
      exp_en = 1'b1; exp_addr = ma; exp_val = md;
      load_ok = 1'b0;
    end
    if (load_ok) mq.push_back('{a: ma, v: md, live: 1'b1});
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 4'h0, 16'h0, 0, 4'h0, 16'h0);
  endtask

  // Assert reset away from the clock edge and check the forced values while it is high.
  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    mq.delete();
    exp_en = 1'b0; exp_addr = 4'h0; exp_val = 16'h0;
    checkAll();
    @(negedge clock);
    #1;
    checkAll();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 0; alu_addr = 0; alu_val = 0;
    mem_valid = 0; mem_addr = 0; mem_val = 0;
    exp_en = 0; exp_addr = 0; exp_val = 0;
    #1;
    checkAll();
    doReset();
    idleCycles(1);

    // Single ALU write to r3.
    applyStimulus(1, 4'h3, 16'h1234, 0, 4'h0, 16'h0);
    idleCycles(2);

    // ALU and load together with an empty buffer: r1 then r2.
    applyStimulus(1, 4'h1, 16'hAAAA, 1, 4'h2, 16'h5555);
    idleCycles(3);

    // ALU busy every cycle while three loads are offered; the third waits for space.
    applyStimulus(1, 4'h7, 16'h0101, 1, 4'h8, 16'hA001);
    applyStimulus(1, 4'h7, 16'h0102, 1, 4'h9, 16'hA002);
    applyStimulus(1, 4'h7, 16'h0103, 1, 4'hA, 16'hA003);
    applyStimulus(0, 4'h0, 16'h0,    1, 4'hA, 16'hA003);
    applyStimulus(0, 4'h0, 16'h0,    1, 4'hA, 16'hA003);
    idleCycles(4);

    // Queued load to r5 superseded by a newer ALU write to r5.
    applyStimulus(1, 4'h1, 16'h0011, 1, 4'h5, 16'hDEAD);
    applyStimulus(1, 4'h5, 16'h0007, 0, 4'h0, 16'h0);
    idleCycles(3);

    // Writes to the zero register never strobe.
    applyStimulus(0, 4'h0, 16'h0, 1, 4'hF, 16'hBEEF);
    applyStimulus(1, 4'hF, 16'hCAFE, 0, 4'h0, 16'h0);
    applyStimulus(1, 4'hF, 16'hCAFE, 1, 4'hF, 16'hF00D);
    idleCycles(2);

    // Reset with two loads queued behind ALU traffic.
    applyStimulus(1, 4'h1, 16'h1111, 1, 4'h2, 16'h2222);
    applyStimulus(1, 4'h3, 16'h3333, 1, 4'h4, 16'h4444);
    doReset();
    idleCycles(4);

    // Random traffic over a small address set so kills and collisions are frequent.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] ra, ma;
      int         pa, pm;
      pa = int'($urandom_range(0, 4));
      pm = int'($urandom_range(0, 4));
      ra = (pa == 4) ? 4'hF : 4'(pa + 4);
      ma = (pm == 4) ? 4'hF : 4'(pm + 4);
      applyStimulus(($urandom_range(0, 99) < 45), ra, 16'($urandom),
                    ($urandom_range(0, 99) < 60), ma, 16'($urandom));
      if (n == 300) doReset();
    end
    idleCycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
